// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: control FSM states,
// the per-stage tracking entry and the forward-select width helper.
package pipe_ctrl_pkg;

    // Stage entries carry the destination index zero-extended to this width
    localparam int RW_MAX = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } stage_entry_t;

    function automatic int fwd_w(input int depth);
        return (depth <= 32'sd2) ? 32'sd1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage / controller bundle: instruction fields in, issue and forwarding
// decisions out.
interface pipe_hazard_ctrl_if #(
    parameter int DEPTH = 3,
    parameter int RW    = 5
);
    localparam int FW = pipe_ctrl_pkg::fwd_w(DEPTH);

    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [RW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_is_load;
    logic          id_halt_req;
    logic          ex_flush;

    logic             id_ready;
    logic             if_id_flush;
    logic [DEPTH-1:0] stage_valid;
    logic [FW-1:0]    ex_fwd_rs1;
    logic [FW-1:0]    ex_fwd_rs2;
    logic             id_wb_bypass_rs1;
    logic             id_wb_bypass_rs2;
    logic             stall;
    logic             is_halted;
    logic [31:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_is_load, id_halt_req, ex_flush,
        input  id_ready, if_id_flush, stage_valid, ex_fwd_rs1, ex_fwd_rs2,
               id_wb_bypass_rs1, id_wb_bypass_rs2, stall, is_halted, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_is_load, id_halt_req, ex_flush,
        output id_ready, if_id_flush, stage_valid, ex_fwd_rs1, ex_fwd_rs2,
               id_wb_bypass_rs1, id_wb_bypass_rs2, stall, is_halted, stall_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Compares one ID source operand against every tracked stage and reports the
// youngest forwardable producer plus a WB-stage hit for the ID bypass.
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RW    = 5
) (
    input  stage_entry_t                stages [DEPTH],
    input  logic [RW-1:0]               src,
    input  logic                        use_src,
    output logic                        hit,
    output logic [fwd_w(DEPTH)-1:0]     idx,
    output logic                        is_load,
    output logic                        wb_hit
);

    localparam int FW = fwd_w(DEPTH);

    logic [DEPTH-1:0] match_s;

    // per-stage producer match; x0 never creates a dependency
    always_comb begin
        match_s = '0;
        for (int j = 0; j < DEPTH; j++) begin
            match_s[j] = stages[j].valid && stages[j].reg_write &&
                         (stages[j].rd == RW_MAX'(src)) &&
                         (src != '0) && use_src;
        end
    end

    // walk oldest to youngest so the youngest forwardable match wins
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            hit     = match_s[j] ? 1'b1 : hit;
            idx     = match_s[j] ? FW'(j) : idx;
            is_load = match_s[j] ? stages[j].is_load : is_load;
        end
    end

    assign wb_hit = match_s[DEPTH-1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: tracks post-ID stages, decides
// load-use stalls, forwarding selects, WB bypass, flush and halt draining.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int RW         = 5
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int FW = fwd_w(DEPTH);

    ctrl_state_e      state_r;
    ctrl_state_e      state_nxt_s;
    stage_entry_t     stage_r [DEPTH];
    logic [FW-1:0]    fwd_rs1_r;
    logic [FW-1:0]    fwd_rs2_r;
    logic [31:0]      stall_count_r;
    logic [DEPTH-1:0] stage_valid_s;

    logic          hit_rs1_s, hit_rs2_s;
    logic          load_rs1_s, load_rs2_s;
    logic          wb_rs1_s, wb_rs2_s;
    logic [FW-1:0] idx_rs1_s, idx_rs2_s;
    logic          run_s, load_use_s, stall_s, id_ready_s;

    hazard_match #(.DEPTH(DEPTH), .RW(RW)) u_match_rs1 (
        .stages  (stage_r),
        .src     (bus.id_rs1),
        .use_src (bus.id_use_rs1),
        .hit     (hit_rs1_s),
        .idx     (idx_rs1_s),
        .is_load (load_rs1_s),
        .wb_hit  (wb_rs1_s)
    );

    hazard_match #(.DEPTH(DEPTH), .RW(RW)) u_match_rs2 (
        .stages  (stage_r),
        .src     (bus.id_rs2),
        .use_src (bus.id_use_rs2),
        .hit     (hit_rs2_s),
        .idx     (idx_rs2_s),
        .is_load (load_rs2_s),
        .wb_hit  (wb_rs2_s)
    );

    // a load only blocks issue while its data will still be short of LOAD_READY next cycle
    always_comb begin
        run_s      = (state_r == ST_RUN);
        load_use_s = (hit_rs1_s && load_rs1_s && ((int'(idx_rs1_s) + 32'sd1) < LOAD_READY)) ||
                     (hit_rs2_s && load_rs2_s && ((int'(idx_rs2_s) + 32'sd1) < LOAD_READY));
        stall_s    = bus.id_valid && run_s && !bus.ex_flush && load_use_s;
        id_ready_s = bus.id_valid && run_s && !bus.ex_flush && !stall_s;
    end

    // stage valid vector
    always_comb begin
        stage_valid_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_valid_s[k] = stage_r[k].valid;
        end
    end

    // output mapping
    always_comb begin
        bus.id_ready         = id_ready_s;
        bus.stall            = stall_s;
        bus.if_id_flush      = bus.ex_flush;
        bus.stage_valid      = stage_valid_s;
        bus.ex_fwd_rs1       = fwd_rs1_r;
        bus.ex_fwd_rs2       = fwd_rs2_r;
        bus.id_wb_bypass_rs1 = wb_rs1_s;
        bus.id_wb_bypass_rs2 = wb_rs2_s;
        bus.is_halted        = (state_r == ST_HALTED);
        bus.stall_count      = stall_count_r;
    end

    // stage shift register; the select is j+1 because the producer advances as the consumer issues
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= '0;
            end
            fwd_rs1_r <= '0;
            fwd_rs2_r <= '0;
        end else begin
            if (id_ready_s) begin
                stage_r[0] <= '{valid:     1'b1,
                                rd:        RW_MAX'(bus.id_rd),
                                reg_write: bus.id_reg_write,
                                is_load:   bus.id_is_load};
                fwd_rs1_r  <= hit_rs1_s ? idx_rs1_s + 1'b1 : '0;
                fwd_rs2_r  <= hit_rs2_s ? idx_rs2_s + 1'b1 : '0;
            end else begin
                stage_r[0] <= '0;
                fwd_rs1_r  <= '0;
                fwd_rs2_r  <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    // saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= 32'd0;
        end else if (stall_s && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // halt sequencing: the halting instruction issues, then the pipe drains
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (id_ready_s && bus.id_halt_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (stage_valid_s == '0) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: each cycle's expected outputs
// are queued with the stimulus and checked by an independent monitor.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       halt;
    } instr_t;

    typedef struct packed {
        logic        ready;
        logic        stall;
        logic        flush;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        b1;
        logic        b2;
        logic [2:0]  sv;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } rec_t;

    logic   clk;
    logic   reset;
    rec_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    instr_t nop_i = '0;

    pipe_hazard_ctrl_if #(.DEPTH(3), .RW(5)) bus ();

    pipe_hazard_ctrl #(.DEPTH(3), .LOAD_READY(2), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t f_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        f_alu = '{v: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, rw: 1'b1, ld: 1'b0, halt: 1'b0};
    endfunction

    function automatic instr_t f_lw(input logic [4:0] rd, input logic [4:0] rs1);
        f_lw = '{v: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, rw: 1'b1, ld: 1'b1, halt: 1'b0};
    endfunction

    function automatic instr_t f_ecall();
        f_ecall = '{v: 1'b1, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0, halt: 1'b1};
    endfunction

    function automatic exp_t exp_v(input logic ready, input logic stall, input logic flush,
                                   input logic [1:0] f1, input logic [1:0] f2,
                                   input logic b1, input logic b2, input logic [2:0] sv,
                                   input logic halted, input logic [31:0] cnt);
        exp_v = '{ready: ready, stall: stall, flush: flush, f1: f1, f2: f2,
                  b1: b1, b2: b2, sv: sv, halted: halted, cnt: cnt};
    endfunction

    task automatic drive(input instr_t i, input logic fl);
        bus.id_valid     = i.v;
        bus.id_rs1       = i.rs1;
        bus.id_rs2       = i.rs2;
        bus.id_use_rs1   = i.u1;
        bus.id_use_rs2   = i.u2;
        bus.id_rd        = i.rd;
        bus.id_reg_write = i.rw;
        bus.id_is_load   = i.ld;
        bus.id_halt_req  = i.halt;
        bus.ex_flush     = fl;
    endtask

    task automatic step(input string nm, input instr_t i, input logic fl, input exp_t e);
        rec_t r;
        drive(i, fl);
        r.name = nm;
        r.e    = e;
        sb_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    // monitor: compare the DUT against the oldest queued expectation mid-cycle
    always @(negedge clk) begin
        rec_t r;
        exp_t a;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            a = '{ready: bus.id_ready, stall: bus.stall, flush: bus.if_id_flush,
                  f1: bus.ex_fwd_rs1, f2: bus.ex_fwd_rs2,
                  b1: bus.id_wb_bypass_rs1, b2: bus.id_wb_bypass_rs2,
                  sv: bus.stage_valid, halted: bus.is_halted, cnt: bus.stall_count};
            n_cmp++;
            if (a !== r.e) begin
                n_bad++;
                $display("FAIL %s: got rdy=%b stl=%b fl=%b f1=%0d f2=%0d b1=%b b2=%b sv=%b h=%b cnt=%0d ; want rdy=%b stl=%b fl=%b f1=%0d f2=%0d b1=%b b2=%b sv=%b h=%b cnt=%0d",
                         r.name, a.ready, a.stall, a.flush, a.f1, a.f2, a.b1, a.b2, a.sv, a.halted, a.cnt,
                         r.e.ready, r.e.stall, r.e.flush, r.e.f1, r.e.f2, r.e.b1, r.e.b2, r.e.sv, r.e.halted, r.e.cnt);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(nop_i, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        step("reset_state", nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,0));

        // independent ALU ops
        step("indep_1", f_alu(5'd1, 5'd2, 5'd3), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,0));
        step("indep_2", f_alu(5'd4, 5'd5, 5'd6), 1'b0, exp_v(1,0,0,0,0,0,0,3'b001,0,0));
        step("indep_3", f_alu(5'd7, 5'd8, 5'd9), 1'b0, exp_v(1,0,0,0,0,0,0,3'b011,0,0));
        step("indep_4", nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b111,0,0));
        step("indep_5", nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b110,0,0));
        step("indep_6", nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b100,0,0));
        step("indep_7", nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,0));

        // ALU forwarding at distance 1 then distance 2
        step("fwd_prod1", f_alu(5'd5, 5'd1, 5'd2), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,0));
        step("fwd_cons1", f_alu(5'd6, 5'd5, 5'd1), 1'b0, exp_v(1,0,0,0,0,0,0,3'b001,0,0));
        step("fwd_ex1",   nop_i, 1'b0, exp_v(0,0,0,1,0,0,0,3'b011,0,0));
        step("fwd_prod2", f_alu(5'd5, 5'd3, 5'd4), 1'b0, exp_v(1,0,0,0,0,0,0,3'b110,0,0));
        step("fwd_mid",   f_alu(5'd9, 5'd2, 5'd3), 1'b0, exp_v(1,0,0,0,0,0,0,3'b101,0,0));
        step("fwd_cons2", f_alu(5'd6, 5'd5, 5'd1), 1'b0, exp_v(1,0,0,0,0,0,0,3'b011,0,0));
        step("fwd_ex2",   nop_i, 1'b0, exp_v(0,0,0,2,0,0,0,3'b111,0,0));
        step("fwd_d1",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b110,0,0));
        step("fwd_d2",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b100,0,0));
        step("fwd_d3",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,0));

        // load-use: one stall, then both operands from MEM
        step("lu_load",   f_lw(5'd5, 5'd1), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,0));
        step("lu_stall",  f_alu(5'd7, 5'd5, 5'd5), 1'b0, exp_v(0,1,0,0,0,0,0,3'b001,0,0));
        step("lu_issue",  f_alu(5'd7, 5'd5, 5'd5), 1'b0, exp_v(1,0,0,0,0,0,0,3'b010,0,1));
        step("lu_ex",     nop_i, 1'b0, exp_v(0,0,0,2,2,0,0,3'b101,0,1));
        step("lu_d1",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b010,0,1));
        step("lu_d2",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b100,0,1));
        step("lu_d3",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,1));

        // WB-stage producer seen by ID through the bypass
        step("byp_prod",  f_alu(5'd8, 5'd1, 5'd2), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,1));
        step("byp_n1",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b001,0,1));
        step("byp_n2",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b010,0,1));
        step("byp_cons",  f_alu(5'd10, 5'd8, 5'd8), 1'b0, exp_v(1,0,0,0,0,1,1,3'b100,0,1));
        step("byp_ex",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b001,0,1));
        step("byp_d1",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b010,0,1));
        step("byp_d2",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b100,0,1));
        step("byp_d3",    nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,1));

        // x0 producer: no stall, forward or bypass
        step("x0_load",   f_lw(5'd0, 5'd1), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,1));
        step("x0_cons1",  f_alu(5'd3, 5'd0, 5'd0), 1'b0, exp_v(1,0,0,0,0,0,0,3'b001,0,1));
        step("x0_n1",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b011,0,1));
        step("x0_cons2",  f_alu(5'd4, 5'd0, 5'd0), 1'b0, exp_v(1,0,0,0,0,0,0,3'b110,0,1));
        step("x0_ex",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b101,0,1));
        step("x0_d1",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b010,0,1));
        step("x0_d2",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b100,0,1));
        step("x0_d3",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,1));

        // flush wins over a load-use stall
        step("fl_load",   f_lw(5'd5, 5'd1), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,1));
        step("fl_flush",  f_alu(5'd7, 5'd5, 5'd5), 1'b1, exp_v(0,0,1,0,0,0,0,3'b001,0,1));
        step("fl_bubble", nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b010,0,1));
        step("fl_d1",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b100,0,1));
        step("fl_d2",     nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,1));

        // halt request coincident with flush is dropped
        step("hf_flush",  f_ecall(), 1'b1, exp_v(0,0,1,0,0,0,0,3'b000,0,1));
        step("hf_idle",   nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,1));

        // halt: issues, drains DEPTH stages, is_halted DEPTH+1 edges after issue
        step("halt_issue", f_ecall(), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,1));
        step("halt_dr0",  f_alu(5'd1, 5'd2, 5'd3), 1'b0, exp_v(0,0,0,0,0,0,0,3'b001,0,1));
        step("halt_dr1",  f_alu(5'd1, 5'd2, 5'd3), 1'b0, exp_v(0,0,0,0,0,0,0,3'b010,0,1));
        step("halt_dr2",  f_alu(5'd1, 5'd2, 5'd3), 1'b0, exp_v(0,0,0,0,0,0,0,3'b100,0,1));
        step("halt_dr3",  f_alu(5'd1, 5'd2, 5'd3), 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,1));
        step("halt_up",   f_alu(5'd1, 5'd2, 5'd3), 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,1,1));
        step("halt_stick", f_ecall(), 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,1,1));

        // reset out of HALTED returns to RUN
        reset = 1'b1;
        drive(nop_i, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("rst_idle",  nop_i, 1'b0, exp_v(0,0,0,0,0,0,0,3'b000,0,0));
        step("rst_run",   f_alu(5'd1, 5'd2, 5'd3), 1'b0, exp_v(1,0,0,0,0,0,0,3'b000,0,0));
        drive(nop_i, 1'b0);

        for (int k = 0; k < 8; k++) begin
            if (sb_q.size() != 0) @(negedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations still pending, 0 required", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DEPTH, default 3: number of tracked stages after ID (0=EX, 1=MEM, 2=WB); legal range 3..8.
REQ-002 Parameter LOAD_READY, default 2: lowest stage index whose pipeline register holds load data; legal range 1..DEPTH-1.
REQ-003 Parameter RW, default 5: register-index width.
REQ-004 Port clk, input, 1: clock; reset, synchronous, active-high; clock clk.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port id_valid, input, 1: ID holds a real instruction.
REQ-007 Port id_rs1 / id_rs2, input, RW each: source indices.
REQ-008 Port id_use_rs1 / id_use_rs2, input, 1 each: operand actually read.
REQ-009 Port id_rd, input, RW: destination index.
REQ-010 Port id_reg_write / id_is_load, input, 1 each: writes rd / is a load.
REQ-011 Port id_halt_req, input, 1: ID holds ecall with x17==10.
REQ-012 Port ex_flush, input, 1: EX resolved a redirect; kill younger instructions.
REQ-013 Port id_ready, output, 1: ID instruction issues this cycle; drives PC write and IF/ID write enables.
REQ-014 Port if_id_flush, output, 1: clear the IF/ID register next edge.
REQ-015 Port stage_valid, output, DEPTH: per-stage valid bits.
REQ-016 Port ex_fwd_rs1 / ex_fwd_rs2, output, $clog2(DEPTH) each: registered EX operand source; 0 = ID/EX register value, k = stage-k pipeline register.
REQ-017 Port id_wb_bypass_rs1 / id_wb_bypass_rs2, output, 1 each: combinational; ID must take the WB write data instead of the register-file read.
REQ-018 Port stall, output, 1: load-use stall this cycle.
REQ-019 Port is_halted, output, 1: pipeline drained after halt.
REQ-020 Port stall_count, output, 32: number of stall cycles.

Function
REQ-021 Each stage entry SHALL hold valid, rd, reg_write and is_load; entries shift one stage per clock, unconditionally.
REQ-022 A hazard match for stage j and operand s SHALL require: stage-j valid, reg_write set, rd==s, s!=0, and use bit set.
REQ-023 stall SHALL be 1 when id_valid is 1, state is RUN, and any operand matches a stage j with is_load set and j+1 < LOAD_READY.
REQ-024 id_ready SHALL equal id_valid & !stall & !ex_flush & state==RUN.
REQ-025 Stage 0 SHALL load the ID fields with valid=id_ready; otherwise it loads a bubble (valid=0).
REQ-026 ex_fwd_sN SHALL be registered on issue as j+1 for the youngest matching stage j <= DEPTH-2, else 0; it is 0 for a bubble.
REQ-027 id_wb_bypass_sN SHALL be 1 when operand N matches stage DEPTH-1.
REQ-028 if_id_flush SHALL equal ex_flush; ex_flush takes priority over stall.
REQ-029 FSM states: RUN, DRAIN, HALTED.
- RUN -> DRAIN when id_ready & id_halt_req; the halting instruction itself issues.
- DRAIN -> HALTED when stage_valid == 0.
- HALTED is sticky until reset.
REQ-030 In DRAIN and HALTED, id_ready SHALL be 0 and stall SHALL be 0.
REQ-031 In RUN, a halt request arriving in the same cycle as ex_flush SHALL be ignored.
REQ-032 is_halted SHALL be 1 only in HALTED.
REQ-033 stall_count SHALL increment once per cycle with stall=1 and saturate at 2^32-1.

Reset
REQ-034 On reset: state RUN, all stage_valid 0, ex_fwd_* 0, stall_count 0, is_halted 0.
REQ-035 Reset asserted mid-drain or in HALTED SHALL return the block to RUN on the next edge.

Structure
REQ-036 Package pipe_ctrl_pkg SHALL hold the FSM state enum, the stage-entry struct and the fwd-select width function.
REQ-037 Sub-module hazard_match SHALL perform the per-operand comparison across all stages, returning the youngest match index and its is_load flag; it is instantiated twice.

Verification
REQ-038 Independent ALU ops with no shared registers -> stall never 1, ex_fwd_* 0, stall_count 0.
REQ-039 add x5 then sub x6,x5,x1 back to back -> ex_fwd_rs1=1 in the sub's EX cycle; with one intervening instruction -> ex_fwd_rs1=2.
REQ-040 lw x5 then add x7,x5,x5 (DEPTH=3, LOAD_READY=2) -> exactly one stall cycle, stall_count=1, then ex_fwd_rs1=ex_fwd_rs2=2.
REQ-041 Producer with rd=x0 followed by a consumer of x0 -> no stall, no forwarding, no bypass.
REQ-042 ex_flush coincident with a load-use stall -> if_id_flush=1, bubble enters stage 0, stall=0.
REQ-043 Halt request issued -> is_halted rises DEPTH+1 cycles later with stage_valid=0; a following reset clears is_halted and the state returns to RUN.
